draw_player_sprite: RTL and testbench

DRAW_PLAYER_SPRITE -- requirements
Module: draw_player_sprite

---
 rtl/player_pkg.sv | 22 ++
 rtl/vga_if.sv | 13 +
 rtl/player_throw_fsm.sv | 93 +++++++++
 rtl/draw_player_sprite.sv | 95 +++++++++
 tb/tb_draw_player_sprite.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/player_pkg.sv
// Types and constants shared by the player sprite renderer and its throw controller.
package player_pkg;

   localparam int FRAME_CNT = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WINDUP = 2'd1,
      THROW  = 2'd2
   } player_state_t;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_sig_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between drawing stages.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/player_throw_fsm.sv
// Throw sequencer: button wind-up measures power, then a fixed hold before completion.
//
// state  | meaning
// IDLE   | waiting for a throw_command rising edge while turn_active
// WINDUP | counting press length; release or timeout starts the throw
// THROW  | holding for HOLD_CYC cycles, then pulse throw_complete
module player_throw_fsm
   import player_pkg::*;
#(
   parameter int HOLD_CYC   = 1000000,
   parameter int WINDUP_MAX = 4000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          turn_active,
   input  logic          throw_command,
   output player_state_t player_state,
   output logic [7:0]    throw_power,
   output logic          throw_complete
);

   localparam int WC_W = $clog2(WINDUP_MAX + 1);
   localparam int HC_W = $clog2(HOLD_CYC + 1);
   localparam logic [WC_W-1:0] WC_MAX  = WC_W'(WINDUP_MAX);
   localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HOLD_CYC - 1);

   player_state_t   state_nxt;
   logic [WC_W-1:0] wcnt, wcnt_nxt, wcnt_inc;
   logic [HC_W-1:0] hcnt, hcnt_nxt;
   logic [WC_W+7:0] wcnt_wide;
   logic [7:0]      power_nxt, power_scaled;
   logic            complete_nxt, cmd_q, cmd_rise, timeout;

   assign cmd_rise  = throw_command & ~cmd_q;
   assign wcnt_inc  = wcnt + WC_W'(1);
   assign timeout   = (wcnt_inc >= WC_MAX);
   // Top 8 bits of the count; short counters are zero-padded up to 8 bits.
   assign wcnt_wide    = {wcnt_inc, 8'd0};
   assign power_scaled = timeout ? 8'hFF : wcnt_wide[WC_W+7 -: 8];

   always_ff @(posedge clk) begin
      if (rst) begin
         player_state   <= IDLE;
         wcnt           <= '0;
         hcnt           <= '0;
         throw_power    <= 8'd0;
         throw_complete <= 1'b0;
         cmd_q          <= 1'b0;
      end else begin
         player_state   <= state_nxt;
         wcnt           <= wcnt_nxt;
         hcnt           <= hcnt_nxt;
         throw_power    <= power_nxt;
         throw_complete <= complete_nxt;
         cmd_q          <= throw_command;
      end
   end

   always_comb begin
      state_nxt    = player_state;
      wcnt_nxt     = '0;
      hcnt_nxt     = hcnt;
      power_nxt    = throw_power;
      complete_nxt = 1'b0;
      case (player_state)
         IDLE: begin
            if (turn_active && cmd_rise) state_nxt = WINDUP;
         end
         WINDUP: begin
            // Release wins over a simultaneous loss of turn.
            if (!throw_command || timeout) begin
               state_nxt = THROW;
               power_nxt = power_scaled;
               hcnt_nxt  = HC_LOAD;
            end else if (!turn_active) begin
               state_nxt = IDLE;
            end else begin
               wcnt_nxt = wcnt_inc;
            end
         end
         THROW: begin
            if (hcnt == '0) begin
               state_nxt    = IDLE;
               complete_nxt = 1'b1;
            end else begin
               hcnt_nxt = hcnt - HC_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/draw_player_sprite.sv
// Overlays the animated player sprite on the VGA stream with a 2-cycle pipeline
// matched to the synchronous sprite ROM; animation frame follows the throw state.
module draw_player_sprite
   import player_pkg::*;
#(
   parameter int          PLAYER_X   = 880,
   parameter int          PLAYER_Y   = 430,
   parameter int          SPR_W      = 140,
   parameter int          SPR_H      = 177,
   parameter logic [11:0] TRANSP     = 12'h000,
   parameter int          MIRROR     = 0,
   parameter int          HOLD_CYC   = 1000000,
   parameter int          WINDUP_MAX = 4000000,
   localparam int         ADDR_W     = $clog2(FRAME_CNT * SPR_W * SPR_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              turn_active,
   input  logic              throw_command,
   input  logic [11:0]       rgb_pix,
   output logic [ADDR_W-1:0] sprite_addr,
   output logic [1:0]        player_state,
   output logic [7:0]        throw_power,
   output logic              throw_complete,
   vga_if.vga_in             vga_in,
   vga_if.vga_out            vga_out
);

   localparam int FRAME_PIX = SPR_W * SPR_H;

   player_state_t     fsm_state;
   vga_sig_t          pix0, pix1, pix2;
   logic              in0, in1, in2;
   logic [1:0]        frame;
   logic [10:0]       rel_x, rel_y, rel_xm;
   logic [ADDR_W-1:0] addr0;

   player_throw_fsm #(
      .HOLD_CYC   (HOLD_CYC),
      .WINDUP_MAX (WINDUP_MAX)
   ) u_throw_fsm (
      .clk            (clk),
      .rst            (rst),
      .turn_active    (turn_active),
      .throw_command  (throw_command),
      .player_state   (fsm_state),
      .throw_power    (throw_power),
      .throw_complete (throw_complete)
   );

   assign player_state = fsm_state;

   assign pix0 = {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync,
                  vga_in.hblnk, vga_in.vblnk, vga_in.rgb};

   always_comb begin
      in0 = (int'(pix0.hcount) >= PLAYER_X) && (int'(pix0.hcount) < PLAYER_X + SPR_W) &&
            (int'(pix0.vcount) >= PLAYER_Y) && (int'(pix0.vcount) < PLAYER_Y + SPR_H);
      rel_x  = pix0.hcount - 11'(PLAYER_X);
      rel_y  = pix0.vcount - 11'(PLAYER_Y);
      rel_xm = (MIRROR != 0) ? (11'(SPR_W - 1) - rel_x) : rel_x;
      // Relative offsets are below SPR_W/SPR_H inside the window, so they fit ADDR_W.
      addr0  = ADDR_W'(frame) * ADDR_W'(FRAME_PIX) +
               ADDR_W'(rel_y) * ADDR_W'(SPR_W) + ADDR_W'(rel_xm);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix1        <= '0;
         pix2        <= '0;
         in1         <= 1'b0;
         in2         <= 1'b0;
         sprite_addr <= '0;
         frame       <= 2'd0;
      end else begin
         pix1        <= pix0;
         pix2        <= pix1;
         in1         <= in0;
         in2         <= in1;
         sprite_addr <= in0 ? addr0 : '0;
         // Frame only changes at the top-left pixel so a sprite is never torn.
         if (pix0.hcount == 11'd0 && pix0.vcount == 11'd0) frame <= player_state;
      end
   end

   assign vga_out.hcount = pix2.hcount;
   assign vga_out.vcount = pix2.vcount;
   assign vga_out.hsync  = pix2.hsync;
   assign vga_out.vsync  = pix2.vsync;
   assign vga_out.hblnk  = pix2.hblnk;
   assign vga_out.vblnk  = pix2.vblnk;
   assign vga_out.rgb    = (in2 && !pix2.hblnk && !pix2.vblnk && rgb_pix != TRANSP) ?
                           rgb_pix : pix2.rgb;

endmodule

// File: tb/tb_draw_player_sprite.sv
// Directed bench for draw_player_sprite: pixel-path vector table plus throw FSM sequences.
`timescale 1ns/1ps
module tb_draw_player_sprite;

   localparam int AW = $clog2(3 * 140 * 177);

   logic          clk = 1'b0;
   logic          rst;
   logic          turn_active, throw_command;
   logic [11:0]   rgb_pix;
   logic [AW-1:0] addr0, addr1;
   logic [1:0]    st0, st1;
   logic [7:0]    pw0, pw1;
   logic          tc0, tc1;
   int            n_tests = 0;
   int            n_fail  = 0;
   int            pulses;

   vga_if vin();
   vga_if vo0();
   vga_if vo1();

   draw_player_sprite #(.MIRROR(0), .HOLD_CYC(10), .WINDUP_MAX(20)) dut0 (
      .clk(clk), .rst(rst), .turn_active(turn_active), .throw_command(throw_command),
      .rgb_pix(rgb_pix), .sprite_addr(addr0), .player_state(st0), .throw_power(pw0),
      .throw_complete(tc0), .vga_in(vin), .vga_out(vo0));

   draw_player_sprite #(.MIRROR(1), .HOLD_CYC(10), .WINDUP_MAX(20)) dut1 (
      .clk(clk), .rst(rst), .turn_active(turn_active), .throw_command(throw_command),
      .rgb_pix(rgb_pix), .sprite_addr(addr1), .player_state(st1), .throw_power(pw1),
      .throw_complete(tc1), .vga_in(vin), .vga_out(vo1));

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0]   h, v;
      logic          hb;
      logic [11:0]   bg, rom;
      logic [AW-1:0] a0, a1;
      logic [11:0]   rgb;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input logic [10:0] h, input logic [10:0] v, input logic hb,
                          input logic [11:0] bg);
      vin.hcount = h;
      vin.vcount = v;
      vin.hblnk  = hb;
      vin.vblnk  = 1'b0;
      vin.hsync  = 1'b0;
      vin.vsync  = 1'b0;
      vin.rgb    = bg;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{11'd880,  11'd430, 1'b0, 12'h0AB, 12'hF00, 17'd0,     17'd139,   12'hF00};
      vecs[1] = '{11'd880,  11'd431, 1'b0, 12'h0AB, 12'h000, 17'd140,   17'd279,   12'h0AB};
      vecs[2] = '{11'd1019, 11'd606, 1'b0, 12'h0AB, 12'h123, 17'd24779, 17'd24640, 12'h123};
      vecs[3] = '{11'd879,  11'd430, 1'b0, 12'h456, 12'hFFF, 17'd0,     17'd0,     12'h456};
      vecs[4] = '{11'd1020, 11'd430, 1'b0, 12'h456, 12'hFFF, 17'd0,     17'd0,     12'h456};
      vecs[5] = '{11'd900,  11'd607, 1'b0, 12'h456, 12'hFFF, 17'd0,     17'd0,     12'h456};
      vecs[6] = '{11'd900,  11'd429, 1'b0, 12'h456, 12'hFFF, 17'd0,     17'd0,     12'h456};
      vecs[7] = '{11'd900,  11'd500, 1'b1, 12'h789, 12'hFFF, 17'd9820,  17'd9919,  12'h789};
      vecs[8] = '{11'd950,  11'd520, 1'b0, 12'h0AB, 12'h7E5, 17'd12670, 17'd12669, 12'h7E5};

      rst = 1'b1; turn_active = 1'b0; throw_command = 1'b0; rgb_pix = 12'h000;
      set_pix(11'd0, 11'd0, 1'b0, 12'h000);
      tick(); tick();
      check("rst_state", 32'(st0), 32'd0);
      check("rst_power", 32'(pw0), 32'd0);
      check("rst_complete", 32'(tc0), 32'd0);
      check("rst_addr", 32'(addr0), 32'd0);
      check("rst_out_rgb", 32'(vo0.rgb), 32'd0);
      check("rst_out_hcount", 32'(vo1.hcount), 32'd0);
      rst = 1'b0;
      tick();

      // Pixel path: address one cycle after the pixel, colour two cycles after.
      for (int i = 0; i < 9; i++) begin
         set_pix(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].bg);
         tick();
         check("addr_m0", 32'(addr0), 32'(vecs[i].a0));
         check("addr_m1", 32'(addr1), 32'(vecs[i].a1));
         tick();
         rgb_pix = vecs[i].rom;
         #1;
         check("rgb_m0", 32'(vo0.rgb), 32'(vecs[i].rgb));
         check("rgb_m1", 32'(vo1.rgb), 32'(vecs[i].rgb));
         check("hcount_out", 32'(vo0.hcount), 32'(vecs[i].h));
      end

      // Sync/timing signals change every cycle and must lag by exactly two cycles.
      for (int i = 0; i < 6; i++) begin
         set_pix(11'(100 + i), 11'(200 + i), i[1], 12'(16 + i));
         vin.hsync = i[0];
         vin.vsync = ~i[0];
         tick();
         if (i >= 1) begin
            check("dly_hcount", 32'(vo0.hcount), 32'(100 + i - 1));
            check("dly_vcount", 32'(vo0.vcount), 32'(200 + i - 1));
            check("dly_hsync", 32'(vo0.hsync), 32'((i - 1) & 1));
            check("dly_hblnk", 32'(vo0.hblnk), 32'(((i - 1) >> 1) & 1));
            check("dly_rgb", 32'(vo1.rgb), 32'(16 + i - 1));
         end
      end

      // Press for 5 cycles then release.
      turn_active = 1'b1; throw_command = 1'b0;
      tick();
      throw_command = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("press_windup", 32'(st0), 32'd1);
      end
      throw_command = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("press_throw", 32'(st0), 32'd2);
         check("press_no_pulse", 32'(tc0), 32'd0);
      end
      tick();
      check("press_idle", 32'(st0), 32'd0);
      check("press_pulse", 32'(tc0), 32'd1);
      check("press_power", 32'(pw0), 32'd40);
      tick();
      check("press_pulse_end", 32'(tc0), 32'd0);

      // Held button: timeout at 20 cycles, full power, no retrigger.
      throw_command = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("hold_windup", 32'(st0), 32'd1);
      end
      tick();
      check("timeout_throw", 32'(st0), 32'd2);
      check("timeout_power", 32'(pw0), 32'd255);
      for (int k = 0; k < 9; k++) tick();
      check("timeout_throw_end", 32'(st0), 32'd2);
      tick();
      check("timeout_idle", 32'(st0), 32'd0);
      check("timeout_pulse", 32'(tc0), 32'd1);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (st0 != 2'd0) pulses += 100;
         if (tc0) pulses++;
      end
      check("no_retrigger", 32'(pulses), 32'd0);
      throw_command = 1'b0;
      tick();

      // Edges while turn_active=0 are ignored, and a held level does not start later.
      turn_active = 1'b0;
      tick();
      throw_command = 1'b1;
      tick(); tick();
      check("no_turn_idle", 32'(st0), 32'd0);
      turn_active = 1'b1;
      tick(); tick();
      check("held_level_idle", 32'(st0), 32'd0);

      // Abort by losing the turn mid-windup.
      throw_command = 1'b0;
      tick();
      throw_command = 1'b1;
      tick(); tick();
      check("abort_windup", 32'(st0), 32'd1);
      turn_active = 1'b0;
      tick();
      check("abort_idle", 32'(st0), 32'd0);
      check("abort_power_kept", 32'(pw0), 32'd255);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (tc0) pulses++;
      end
      check("abort_no_pulse", 32'(pulses), 32'd0);

      // Release and turn loss in the same cycle: release wins.
      turn_active = 1'b1; throw_command = 1'b0;
      tick();
      throw_command = 1'b1;
      tick();
      throw_command = 1'b0; turn_active = 1'b0;
      tick();
      check("prio_throw", 32'(st0), 32'd2);
      check("prio_power", 32'(pw0), 32'd8);
      turn_active = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (tc0) pulses++;
      end
      check("prio_one_pulse", 32'(pulses), 32'd1);
      check("prio_idle", 32'(st1), 32'd0);

      // Reset in the middle of THROW.
      tick();
      throw_command = 1'b1;
      tick(); tick();
      throw_command = 1'b0;
      tick();
      check("rst_seq_throw", 32'(st0), 32'd2);
      check("rst_seq_power", 32'(pw0), 32'd16);
      tick(); tick();
      rst = 1'b1;
      tick();
      check("midthrow_rst_state", 32'(st0), 32'd0);
      check("midthrow_rst_power", 32'(pw1), 32'd0);
      check("midthrow_rst_complete", 32'(tc0), 32'd0);
      check("midthrow_rst_addr", 32'(addr0), 32'd0);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (tc0 || tc1) pulses++;
      end
      check("midthrow_rst_no_pulse", 32'(pulses), 32'd0);

      // Frame offset follows the state only after the next (0,0) pixel.
      set_pix(11'd880, 11'd430, 1'b0, 12'h000);
      tick();
      throw_command = 1'b1;
      tick(); tick(); tick();
      check("frame_state_windup", 32'(st0), 32'd1);
      check("frame_old_m0", 32'(addr0), 32'd0);
      check("frame_old_m1", 32'(addr1), 32'd139);
      set_pix(11'd0, 11'd0, 1'b0, 12'h000);
      tick();
      set_pix(11'd880, 11'd430, 1'b0, 12'h000);
      tick();
      check("frame_new_m0", 32'(addr0), 32'd24780);
      check("frame_new_m1", 32'(addr1), 32'd24919);
      throw_command = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
